// File: rtl/booth_mul_sched.sv
// Shared sequential radix-2 Booth multiplier serving two requesters.
// Define BOOTH_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module booth_mul_sched #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req,
    input  logic [W-1:0]   mcand0,
    input  logic [W-1:0]   mplier0,
    input  logic [W-1:0]   mcand1,
    input  logic [W-1:0]   mplier1,
    output logic [1:0]     gnt,
    output logic [1:0]     done,
    output logic [2*W-1:0] product,
    output logic           busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(W) + 1;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic           sel;
    logic [W:0]     mc;
    // {A[W:0], Q[W-1:0], Q_-1}
    logic [2*W+1:0] acc;
    logic [W:0]     sum;
    logic [2*W+1:0] acc_next;
    logic           pick;
    logic [W-1:0]   pick_mcand;
    logic [W-1:0]   pick_mplier;

`ifdef BOOTH_SCHED_RR_EN
    logic last;
    assign pick = (req == 2'b11) ? ~last : (req[1] & ~req[0]);
`else
    assign pick = ~req[0];
`endif

    assign pick_mcand  = pick ? mcand1  : mcand0;
    assign pick_mplier = pick ? mplier1 : mplier0;

    always_comb begin
        sum = acc[2*W+1:W+1];
        case (acc[1:0])
            2'b01:   sum = acc[2*W+1:W+1] + mc;
            2'b10:   sum = acc[2*W+1:W+1] - mc;
            default: sum = acc[2*W+1:W+1];
        endcase
        // arithmetic shift right of {sum, Q, Q_-1}
        acc_next = {sum[W], sum, acc[W:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            product <= '0;
            cnt     <= '0;
            sel     <= 1'b0;
            mc      <= '0;
            acc     <= '0;
`ifdef BOOTH_SCHED_RR_EN
            last    <= 1'b1;
`endif
        end else begin
            gnt  <= 2'b00;
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        sel   <= pick;
                        mc    <= {pick_mcand[W-1], pick_mcand};
                        acc   <= {{(W+1){1'b0}}, pick_mplier, 1'b0};
                        gnt   <= pick ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= RUN;
`ifdef BOOTH_SCHED_RR_EN
                        last  <= pick;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1)) begin
                        product <= acc_next[2*W:1];
                        done    <= sel ? 2'b10 : 2'b01;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: vector table, scoreboard, arbitration and reset sequences.
module tb_booth_mul_sched;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req = 2'b00;
    logic [W-1:0]   mcand0 = '0, mplier0 = '0, mcand1 = '0, mplier1 = '0;
    logic [1:0]     gnt, done;
    logic [2*W-1:0] product;
    logic           busy;

    booth_mul_sched #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .mcand0(mcand0), .mplier0(mplier0), .mcand1(mcand1), .mplier1(mplier1),
        .gnt(gnt), .done(done), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     d;
        logic [2*W-1:0] p;
    } exp_t;
    typedef struct {
        bit             r;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] e;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   nvec = 0, nerr = 0;
    int   cyc = 0, gnt_cyc = 0, ndone = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] mref(input logic [W-1:0] a, input logic [W-1:0] b);
        int x;
        x = int'($signed(a)) * int'($signed(b));
        return x[2*W-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != 2'b00) begin
                gnt_cyc <= cyc;
                check("gnt_onehot", $countones(gnt), 1);
            end
            if (done != 2'b00) begin
                ndone <= ndone + 1;
                if (sbq.size() == 0) begin
                    check("unexpected_done", {30'd0, done}, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("done_sel", {30'd0, done}, {30'd0, mon_e.d});
                    check("product", {24'd0, product}, {24'd0, mon_e.p});
                    check("latency", cyc - gnt_cyc, W);
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic op(input bit r, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] e, input bit chg);
        int n0, k;
        wait_idle();
        @(negedge clk);
        if (r) begin
            mcand1 = a; mplier1 = b; mcand0 = ~a; mplier0 = b + 4'd1;
        end else begin
            mcand0 = a; mplier0 = b; mcand1 = ~a; mplier1 = b + 4'd1;
        end
        req = r ? 2'b10 : 2'b01;
        sbq.push_back('{r ? 2'b10 : 2'b01, e});
        n0 = ndone;
        @(posedge clk); #1;
        check("gnt", {30'd0, gnt}, r ? 2 : 1);
        check("busy_at_gnt", {31'd0, busy}, 1);
        req = 2'b00;
        if (chg) begin
            @(posedge clk); #1;
            mcand0 = mcand0 + 4'd6;
            mplier0 = mplier0 + 4'd3;
        end
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (ndone == n0 && k < 3*W);
        check("done_seen", ndone - n0, 1);
        check("busy_in_done", {31'd0, busy}, 1);
        @(negedge clk); #1;
        check("busy_after", {31'd0, busy}, 0);
        check("done_pulse", {30'd0, done}, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t tv[8];

    initial begin
        tv[0] = '{1'b0, 4'd3, 4'hE, 8'hFA};
        tv[1] = '{1'b0, 4'h8, 4'h8, 8'h40};
        tv[2] = '{1'b1, 4'd7, 4'h8, 8'hC8};
        tv[3] = '{1'b0, 4'd0, 4'd5, 8'h00};
        tv[4] = '{1'b1, 4'hF, 4'hF, 8'h01};
        tv[5] = '{1'b1, 4'h8, 4'd7, 8'hC8};
        tv[6] = '{1'b0, 4'd7, 4'd7, 8'h31};
        tv[7] = '{1'b1, 4'd5, 4'hD, 8'hF1};

        #1;
        check("rst_gnt", {30'd0, gnt}, 0);
        check("rst_done", {30'd0, done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_product", {24'd0, product}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) op(tv[i].r, tv[i].a, tv[i].b, tv[i].e, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            op(i[0], a, b, mref(a, b), 1'b0);
        end

        // latched operands only: 3 x 5 despite later changes
        op(1'b0, 4'd3, 4'd5, 8'h0F, 1'b1);

        // both requesters held: fixed priority starves 1, round-robin alternates
        begin
            int k, prev;
            logic [1:0] eg;
            pulse_reset();
            @(negedge clk);
            mcand0 = 4'd2; mplier0 = 4'd3; mcand1 = 4'hD; mplier1 = 4'd5;
            req = 2'b11;
            prev = 0;
            for (int i = 0; i < 4; i++) begin
                k = 0;
                do begin
                    @(negedge clk); #1;
                    k++;
                end while (gnt == 2'b00 && k < 20);
`ifdef BOOTH_SCHED_RR_EN
                eg = i[0] ? 2'b10 : 2'b01;
`else
                eg = (i == 3) ? 2'b10 : 2'b01;
`endif
                check("hold_gnt", {30'd0, gnt}, {30'd0, eg});
                if (i > 0) check("hold_gap", cyc - prev, W + 2);
                prev = cyc;
                sbq.push_back('{eg, eg[1] ? mref(mcand1, mplier1) : mref(mcand0, mplier0)});
                if (i == 2) req = 2'b10;
                if (i == 3) req = 2'b00;
            end
            wait_idle();
            repeat (2) @(negedge clk);
            check("sb_drained", sbq.size(), 0);
        end

        // reset during iteration 2 aborts without a done pulse
        @(negedge clk);
        mcand0 = 4'd5; mplier0 = 4'd3; req = 2'b01;
        @(posedge clk); #1;
        req = 2'b00;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_gnt", {30'd0, gnt}, 0);
        check("abort_done", {30'd0, done}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_product", {24'd0, product}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        op(1'b1, 4'hA, 4'd3, mref(4'hA, 4'd3), 1'b0);
        check("sb_final", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
